// File: rtl/guitar_input_conditioner.sv
// guitar_input_conditioner: synchronize/debounce guitar frets and strum levers, derive level bus, sticky hits and strum counters
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   p1b1..p1b3, p2b1..p2b3 raw active-low fret buttons (asynchronous)
//   p1ls, p2ls            raw active-high strum levers (asynchronous)
//   hit_clear[5:0]        per-bit clear of hits (same bit order as hits)
//   guitar_in[5:0]        fret pressed AND that player's lever active
//   hits[5:0]             sticky fret-at-strum flags
//   strum_cnt_p1/p2[7:0]  wrapping strum event counters
module guitar_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       p1b1,
    input  logic       p1b2,
    input  logic       p1b3,
    input  logic       p1ls,
    input  logic       p2b1,
    input  logic       p2b2,
    input  logic       p2b3,
    input  logic       p2ls,
    input  logic [5:0] hit_clear,
    output logic [5:0] guitar_in,
    output logic [5:0] hits,
    output logic [7:0] strum_cnt_p1,
    output logic [7:0] strum_cnt_p2
);
    // Channel order: [5:0] frets (p1b1..p2b3), [6] p1ls, [7] p2ls.
    // Idle value: frets released (high), levers inactive (low).
    localparam logic [7:0]       IDLE     = 8'h3F;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [7:0]       raw;
    logic [7:0]       meta_q;
    logic [7:0]       sync_q;
    logic [7:0]       stable_q;
    logic [7:0]       stable_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [1:0]       ls_d_q;
    logic [1:0]       strum_evt;
    logic [5:0]       pressed;
    logic [5:0]       active;
    logic [5:0]       hit_set;
    logic [5:0]       hits_q;
    logic [5:0]       hits_d;
    logic [7:0]       cnt_p1_q;
    logic [7:0]       cnt_p1_d;
    logic [7:0]       cnt_p2_q;
    logic [7:0]       cnt_p2_d;
    assign raw = {p2ls, p1ls, p2b3, p2b2, p2b1, p1b3, p1b2, p1b1};
    // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES samples.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST)
                    stable_d[i] = sync_q[i];
                else
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end
    assign pressed   = ~stable_q[5:0];
    assign active    = {{3{stable_q[7]}}, {3{stable_q[6]}}};
    assign guitar_in = pressed & active;
    assign strum_evt = stable_q[7:6] & ~ls_d_q;
    // A hit landing in the same cycle as its clear wins.
    assign hit_set   = pressed & {{3{strum_evt[1]}}, {3{strum_evt[0]}}};
    assign hits_d    = hit_set | (hits_q & ~hit_clear);
    assign cnt_p1_d  = strum_evt[0] ? cnt_p1_q + 8'd1 : cnt_p1_q;
    assign cnt_p2_d  = strum_evt[1] ? cnt_p2_q + 8'd1 : cnt_p2_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q   <= IDLE;
            sync_q   <= IDLE;
            stable_q <= IDLE;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
            ls_d_q   <= '0;
            hits_q   <= '0;
            cnt_p1_q <= '0;
            cnt_p2_q <= '0;
        end else begin
            meta_q   <= raw;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
            ls_d_q   <= stable_q[7:6];
            hits_q   <= hits_d;
            cnt_p1_q <= cnt_p1_d;
            cnt_p2_q <= cnt_p2_d;
        end
    end
    assign hits         = hits_q;
    assign strum_cnt_p1 = cnt_p1_q;
    assign strum_cnt_p2 = cnt_p2_q;
endmodule

// File: tb/tb_guitar_input_conditioner.sv
// tb_guitar_input_conditioner: scoreboard-driven directed bench for guitar_input_conditioner
module tb_guitar_input_conditioner;
    logic       clock;
    logic       reset;
    logic       p1b1, p1b2, p1b3, p1ls;
    logic       p2b1, p2b2, p2b3, p2ls;
    logic [5:0] hit_clear;
    logic [5:0] guitar_in;
    logic [5:0] hits;
    logic [7:0] strum_cnt_p1;
    logic [7:0] strum_cnt_p2;

    guitar_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(18)) dut (
        .clock(clock), .reset(reset),
        .p1b1(p1b1), .p1b2(p1b2), .p1b3(p1b3), .p1ls(p1ls),
        .p2b1(p2b1), .p2b2(p2b2), .p2b3(p2b3), .p2ls(p2ls),
        .hit_clear(hit_clear), .guitar_in(guitar_in), .hits(hits),
        .strum_cnt_p1(strum_cnt_p1), .strum_cnt_p2(strum_cnt_p2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          due;
        string       tag;
        logic [27:0] exp;
    } exp_t;

    exp_t       sb[$];
    int         cyc   = 0;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] c1_m;

    // Expect {guitar_in, hits, strum_cnt_p1, strum_cnt_p2} as seen after k more clock edges.
    task automatic exp_after(input int k, input string tag, input logic [5:0] gi, input logic [5:0] h,
                             input logic [7:0] c1, input logic [7:0] c2);
        exp_t e;
        e.due = cyc + k;
        e.tag = tag;
        e.exp = {gi, h, c1, c2};
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        exp_t        e;
        logic [27:0] obs;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e   = sb.pop_front();
                obs = {guitar_in, hits, strum_cnt_p1, strum_cnt_p2};
                tests++;
                assert (obs === e.exp && e.due == cyc) else begin
                    fails++;
                    $error("FAIL %s: cycle %0d due %0d got gi/hits/c1/c2=%h required %h",
                           e.tag, cyc, e.due, obs, e.exp);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        {p1b1, p1b2, p1b3, p2b1, p2b2, p2b3} = 6'h3F;
        p1ls = 1'b0;
        p2ls = 1'b0;
        hit_clear = '0;
        exp_after(1, "in_reset", 6'h00, 6'h00, 8'd0, 8'd0);
        run(2);
        reset = 1'b0;
        exp_after(1, "idle1", 6'h00, 6'h00, 8'd0, 8'd0);
        exp_after(6, "idle6", 6'h00, 6'h00, 8'd0, 8'd0);
        run(6);

        p2b1 = 1'b0;
        run(8);
        p2ls = 1'b1;
        run(3);
        p2ls = 1'b0;
        exp_after(3, "p2_glitch3", 6'h00, 6'h00, 8'd0, 8'd0);
        exp_after(9, "p2_glitch9", 6'h00, 6'h00, 8'd0, 8'd0);
        run(9);
        p2b1 = 1'b1;
        run(6);

        p1b2 = 1'b0;
        run(8);
        p1ls = 1'b1;
        exp_after(5, "pre_accept", 6'h00, 6'h00, 8'd0, 8'd0);
        exp_after(6, "accept", 6'h02, 6'h00, 8'd0, 8'd0);
        exp_after(7, "strum1", 6'h02, 6'h02, 8'd1, 8'd0);
        exp_after(12, "held", 6'h02, 6'h02, 8'd1, 8'd0);
        run(12);
        p1ls = 1'b0;
        exp_after(8, "lever_rel", 6'h00, 6'h02, 8'd1, 8'd0);
        run(8);

        hit_clear = 6'h02;
        exp_after(1, "clear", 6'h00, 6'h00, 8'd1, 8'd0);
        run(1);
        hit_clear = '0;
        p1ls = 1'b1;
        exp_after(6, "pre_hit", 6'h02, 6'h00, 8'd1, 8'd0);
        run(6);
        hit_clear = 6'h02;
        exp_after(1, "hit_beats_clear", 6'h02, 6'h02, 8'd2, 8'd0);
        run(1);
        hit_clear = '0;
        p1ls = 1'b0;
        p1b2 = 1'b1;
        exp_after(8, "all_rel", 6'h00, 6'h02, 8'd2, 8'd0);
        run(8);
        hit_clear = 6'h3F;
        exp_after(1, "clear_all", 6'h00, 6'h00, 8'd2, 8'd0);
        run(1);
        hit_clear = '0;

        c1_m = 8'd2;
        for (int s = 0; s < 256; s++) begin
            p1ls = 1'b1;
            exp_after(7, "wrap_strum", 6'h00, 6'h00, c1_m + 8'd1, 8'd0);
            run(7);
            c1_m = c1_m + 8'd1;
            p1ls = 1'b0;
            run(6);
        end
        exp_after(1, "after_wrap", 6'h00, 6'h00, 8'd2, 8'd0);
        run(1);

        p2ls = 1'b1;
        run(3);
        reset = 1'b1;
        exp_after(1, "mid_reset", 6'h00, 6'h00, 8'd0, 8'd0);
        run(1);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) exp_after(k, "restart_wait", 6'h00, 6'h00, 8'd0, 8'd0);
        exp_after(7, "p2_strum", 6'h00, 6'h00, 8'd0, 8'd1);
        exp_after(12, "one_event", 6'h00, 6'h00, 8'd0, 8'd1);
        run(12);

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
